// File: rtl/program_counter.sv
// Instruction-address register for the CPU datapath. It advances by STEP every
// clock, takes a jump/branch target on load, and returns to RESET_VALUE on reset.
module program_counter #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] STEP        = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             load,
    output logic [WIDTH-1:0] pc_out
);

    // Priority order is reset, then load, then increment. The increment wraps
    // modulo 2^WIDTH because the sum is truncated to WIDTH bits.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking, so every other reader of pc_out on this edge sees the pre-edge value.
        if (reset)
            pc_out <= RESET_VALUE;
        else if (load)
            pc_out <= pc_in;
        else
            pc_out <= pc_out + STEP;
    end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios with literal
// expectations, then randomized traffic checked against an arithmetic model.
module tb_program_counter;

    localparam int WIDTH = 16;
    localparam int MODULUS = 1 << WIDTH;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] pc_in;
    logic             load;
    logic [WIDTH-1:0] pc_out;

    int compared;
    int mismatched;

    program_counter #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(16'h0000),
        .STEP       (16'h0001)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pc_in (pc_in),
        .load  (load),
        .pc_out(pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic drive(input logic r, input logic l, input logic [WIDTH-1:0] p);
        @(negedge clk);
        reset = r;
        load  = l;
        pc_in = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 16'h0000);
        compared++;
        if (pc_out !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_value: got %h expected %h", pc_out, 16'h0000);
        end
    endtask

    task automatic test_count();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0, 16'h0000);
            compared++;
            if (pc_out !== 16'(i)) begin
                mismatched++;
                $display("FAIL count_%0d: got %h expected %h", i, pc_out, 16'(i));
            end
        end
    endtask

    task automatic test_load();
        drive(1'b0, 1'b1, 16'h00A0);
        compared++;
        if (pc_out !== 16'h00A0) begin
            mismatched++;
            $display("FAIL load_00a0: got %h expected %h", pc_out, 16'h00A0);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b0, 16'h5555);
            compared++;
            if (pc_out !== 16'(16'h00A0 + i)) begin
                mismatched++;
                $display("FAIL after_load_%0d: got %h expected %h", i, pc_out, 16'(16'h00A0 + i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] wrap_exp [3];
        wrap_exp[0] = 16'hFFFF;
        wrap_exp[1] = 16'h0000;
        wrap_exp[2] = 16'h0001;
        drive(1'b0, 1'b1, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) drive(1'b0, 1'b0, 16'h0000);
            compared++;
            if (pc_out !== wrap_exp[i]) begin
                mismatched++;
                $display("FAIL wrap_%0d: got %h expected %h", i, pc_out, wrap_exp[i]);
            end
        end
    endtask

    task automatic test_reset_with_load();
        drive(1'b1, 1'b1, 16'h1234);
        compared++;
        if (pc_out !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_beats_load: got %h expected %h", pc_out, 16'h0000);
        end
        drive(1'b0, 1'b0, 16'h1234);
        compared++;
        if (pc_out !== 16'h0001) begin
            mismatched++;
            $display("FAIL resume_after_reset_load: got %h expected %h", pc_out, 16'h0001);
        end
    endtask

    task automatic test_reset_mid_count();
        drive(1'b0, 1'b1, 16'h0041);
        drive(1'b0, 1'b0, 16'h0000);
        compared++;
        if (pc_out !== 16'h0042) begin
            mismatched++;
            $display("FAIL pre_reset_0042: got %h expected %h", pc_out, 16'h0042);
        end
        drive(1'b1, 1'b0, 16'h0000);
        compared++;
        if (pc_out !== 16'h0000) begin
            mismatched++;
            $display("FAIL mid_count_reset: got %h expected %h", pc_out, 16'h0000);
        end
        drive(1'b0, 1'b0, 16'h0000);
        compared++;
        if (pc_out !== 16'h0001) begin
            mismatched++;
            $display("FAIL resume_after_mid_reset: got %h expected %h", pc_out, 16'h0001);
        end
    endtask

    task automatic test_load_held();
        logic [WIDTH-1:0] target;
        for (int i = 0; i < 4; i++) begin
            target = 16'($urandom);
            drive(1'b0, 1'b1, target);
            compared++;
            if (pc_out !== target) begin
                mismatched++;
                $display("FAIL load_held_%0d: got %h expected %h", i, pc_out, target);
            end
        end
        // Reloading the current value must leave it unchanged, not add a step.
        drive(1'b0, 1'b1, target);
        compared++;
        if (pc_out !== target) begin
            mismatched++;
            $display("FAIL load_same_value: got %h expected %h", pc_out, target);
        end
    endtask

    // pc_out must not move when inputs change between edges.
    task automatic test_no_comb_path();
        logic [WIDTH-1:0] held;
        @(negedge clk);
        held  = pc_out;
        reset = 1'b1;
        load  = 1'b1;
        pc_in = ~held;
        #2;
        compared++;
        if (pc_out !== held) begin
            mismatched++;
            $display("FAIL no_comb_path: got %h expected %h", pc_out, held);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int unsigned model;
        logic r, l;
        logic [WIDTH-1:0] p;
        drive(1'b1, 1'b0, 16'h0000);
        model = 0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(15) == 0);
            l = ($urandom_range(3) == 0);
            p = ($urandom_range(3) == 0) ? 16'(16'hFFFF - $urandom_range(2)) : 16'($urandom);
            drive(r, l, p);
            if (r)      model = 0;
            else if (l) model = int'(p);
            else        model = (model + 1) % MODULUS;
            compared++;
            if (pc_out !== 16'(model)) begin
                mismatched++;
                $display("FAIL random_%0d: got %h expected %h (reset=%b load=%b pc_in=%h)",
                         i, pc_out, 16'(model), r, l, p);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        load       = 1'b0;
        pc_in      = '0;
        test_reset();
        test_count();
        test_load();
        test_wrap();
        test_reset_with_load();
        test_reset_mid_count();
        test_load_held();
        test_no_comb_path();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
